// File: rtl/accel_top_if.sv
// -----------------------------------------------------------------------------
// accel_top_if.sv
// Bus bundles used by the image-editing accelerator.
//   axil_if : AXI4-Lite register channel (AW/W/B/AR/R).
//             master drives addresses, write data and the ready of B/R;
//             slave drives the channel readies, bresp/bvalid and rdata/rresp/rvalid.
//   axis_if : AXI4-Stream channel (tvalid/tready/tdata/tstrb/tlast).
//             master drives everything except tready.
// -----------------------------------------------------------------------------
interface axil_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface axis_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;

    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/accel_top.sv
// -----------------------------------------------------------------------------
// accel_top.sv
// Streaming image-editing accelerator. A frame of packed 8-bit pixels (four per
// word, first pixel in [31:24]) is captured from s_axis into a buffer, then
// replayed on m_axis with a per-byte edit (invert / pass / add-sat / sub-sat).
// Ports:
//   clk    : single clock
//   rst    : synchronous active-high reset
//   s_axi  : AXI4-Lite slave; CTRL(0x0) MODE(0x4) PARAM(0x8) STATUS(0xC)
//   s_axis : AXI4-Stream input frame
//   m_axis : AXI4-Stream edited output frame, tlast on the final word
// -----------------------------------------------------------------------------
module accel_top #(
    parameter int FRAME_WORDS = 576,
    parameter int ADDR_W      = 10
) (
    input  logic   clk,
    input  logic   rst,
    axil_if.slave  s_axi,
    axis_if.slave  s_axis,
    axis_if.master m_axis
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    // Per-pixel edit operation.
    function automatic logic [7:0] edit_pixel(input logic [7:0] x,
                                              input logic [1:0] mode,
                                              input logic [7:0] param);
        logic [8:0] sum;
        logic [8:0] diff;
        sum  = {1'b0, x} + {1'b0, param};
        diff = {1'b0, x} - {1'b0, param};
        case (mode)
            2'd0:    edit_pixel = 8'hFF - x;
            2'd1:    edit_pixel = x;
            2'd2:    edit_pixel = sum[8]  ? 8'hFF : sum[7:0];
            2'd3:    edit_pixel = diff[8] ? 8'h00 : diff[7:0];
            default: edit_pixel = x;
        endcase
    endfunction

    // Applies the pixel edit to all four bytes of a word.
    function automatic logic [31:0] edit_word(input logic [31:0] w,
                                              input logic [1:0]  mode,
                                              input logic [7:0]  param);
        logic [31:0] r;
        r = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = edit_pixel(w[b*8 +: 8], mode, param);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------ regs
    logic              wr_rdy_q, wr_rdy_d;
    logic              bvalid_q, bvalid_d;
    logic              rd_rdy_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [31:0]       reg_rdata_s;
    logic [1:0]        mode_q;
    logic [7:0]        param_q;
    logic [1:0]        run_mode_q;
    logic [7:0]        run_param_q;
    logic              done_q;
    logic              busy_q;
    logic [ADDR_W-1:0] count_q;

    state_t            state_q, state_d;
    logic              s_tready_q;
    logic [ADDR_W-1:0] n_q;

    logic [31:0]       mem [0:FRAME_WORDS-1];
    logic [31:0]       rd_word_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic              rd_vld_q;
    logic              rd_last_q;
    logic [31:0]       m_data_q;
    logic              m_valid_q;
    logic              m_last_q;
    logic [31:0]       sk_data_q;
    logic              sk_valid_q;
    logic              sk_last_q;

    logic              wr_fire_s;
    logic [1:0]        wr_sel_s;
    logic              rd_fire_s;
    logic              start_s;
    logic              start_ok_s;
    logic              in_fire_s;
    logic              in_end_s;
    logic              pop_s;
    logic              frame_end_s;
    logic              issue_s;
    logic [2:0]        used_s;
    logic [31:0]       push_data_s;
    logic              unused_s;

    assign wr_fire_s   = wr_rdy_q & s_axi.awvalid & s_axi.wvalid;
    assign wr_sel_s    = s_axi.awaddr[3:2];
    assign rd_fire_s   = rd_rdy_q & s_axi.arvalid;
    assign start_s     = wr_fire_s & (wr_sel_s == 2'd0) & s_axi.wstrb[0] & s_axi.wdata[0];
    // A start is only honoured when no frame is in flight.
    assign start_ok_s  = start_s & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign in_fire_s   = s_tready_q & s_axis.tvalid;
    assign in_end_s    = in_fire_s & (s_axis.tlast | (n_q == LAST_IDX));
    assign pop_s       = m_valid_q & m_axis.tready;
    assign frame_end_s = pop_s & m_last_q;

    // Bits of the buses that carry no meaning for this block.
    assign unused_s = ^{s_axi.awaddr[31:4], s_axi.awaddr[1:0], s_axi.awprot,
                        s_axi.araddr[1:0], s_axi.arprot, s_axi.wstrb[3:1],
                        s_axi.wdata[31:8], s_axis.tstrb};

    // Write handshake: single-cycle ready pulse, response held until bready.
    always_comb begin
        wr_rdy_d = 1'b0;
        bvalid_d = bvalid_q;
        if (!wr_rdy_q && !bvalid_q && s_axi.awvalid && s_axi.wvalid) begin
            wr_rdy_d = 1'b1;
        end else begin
            wr_rdy_d = 1'b0;
        end
        if (wr_fire_s) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
    end

    // Write handshake state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            wr_rdy_q <= wr_rdy_d;
            bvalid_q <= bvalid_d;
        end
    end

    // MODE / PARAM registers; both fields live in byte lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 2'd0;
            param_q <= 8'd0;
        end else if (wr_fire_s && s_axi.wstrb[0]) begin
            case (wr_sel_s)
                2'd1:    mode_q  <= s_axi.wdata[1:0];
                2'd2:    param_q <= s_axi.wdata[7:0];
                default: ;
            endcase
        end
    end

    // Register read mux.
    always_comb begin
        reg_rdata_s = 32'h0000_0000;
        case (s_axi.araddr[3:2])
            2'd0:    reg_rdata_s = 32'h0000_0000;
            2'd1:    reg_rdata_s = {30'd0, mode_q};
            2'd2:    reg_rdata_s = {24'd0, param_q};
            2'd3:    reg_rdata_s = {6'd0, count_q, 14'd0, done_q, busy_q};
            default: reg_rdata_s = 32'h0000_0000;
        endcase
    end

    // Read handshake: arready pulse, then registered data held until rready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_rdy_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0000_0000;
        end else begin
            rd_rdy_q <= !rd_rdy_q && !rvalid_q && s_axi.arvalid;
            if (rd_fire_s) begin
                rvalid_q <= 1'b1;
                rdata_q  <= reg_rdata_s;
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Frame sequencing next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok_s)  state_d = ST_LOAD; else state_d = ST_IDLE;
            ST_LOAD: if (in_end_s)    state_d = ST_SEND; else state_d = ST_LOAD;
            ST_SEND: if (frame_end_s) state_d = ST_DONE; else state_d = ST_SEND;
            ST_DONE: if (start_ok_s)  state_d = ST_LOAD; else state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus flags derived from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_tready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_tready_q <= (state_d == ST_LOAD);
            busy_q     <= (state_d == ST_LOAD) || (state_d == ST_SEND);
        end
    end

    // Frame length, latched edit settings and completion status.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q         <= '0;
            run_mode_q  <= 2'd0;
            run_param_q <= 8'd0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            if (start_ok_s) begin
                n_q         <= '0;
                run_mode_q  <= mode_q;
                run_param_q <= param_q;
                done_q      <= 1'b0;
            end else if (in_fire_s) begin
                n_q <= n_q + ONE_A;
            end
            if (frame_end_s) begin
                done_q  <= 1'b1;
                count_q <= n_q;
            end
        end
    end

    // Frame buffer: raw capture on input beats, registered read for replay.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            mem[n_q] <= s_axis.tdata;
        end
        if (issue_s) begin
            rd_word_q <= mem[rd_ptr_q];
        end
    end

    // Slots already committed after this edge: output reg, skid reg and the
    // word now arriving from the buffer, minus one if the head is consumed.
    // A new read is issued only if its word will have a free slot.
    assign used_s      = 3'(m_valid_q) + 3'(sk_valid_q) + 3'(rd_vld_q) - 3'(pop_s);
    assign issue_s     = (state_q == ST_SEND) && (rd_ptr_q < n_q) && (used_s <= 3'd1);
    assign push_data_s = edit_word(rd_word_q, run_mode_q, run_param_q);

    // Output path: buffer read stage feeding an output register with a skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            m_data_q   <= 32'h0000_0000;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            sk_data_q  <= 32'h0000_0000;
            sk_valid_q <= 1'b0;
            sk_last_q  <= 1'b0;
        end else if (start_ok_s) begin
            rd_ptr_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_last_q  <= 1'b0;
        end else begin
            rd_vld_q <= issue_s;
            if (issue_s) begin
                rd_ptr_q  <= rd_ptr_q + ONE_A;
                rd_last_q <= (rd_ptr_q == (n_q - ONE_A));
            end
            if (pop_s) begin
                if (sk_valid_q) begin
                    m_data_q <= sk_data_q;
                    m_last_q <= sk_last_q;
                    if (rd_vld_q) begin
                        sk_data_q <= push_data_s;
                        sk_last_q <= rd_last_q;
                    end else begin
                        sk_valid_q <= 1'b0;
                        sk_last_q  <= 1'b0;
                    end
                end else if (rd_vld_q) begin
                    m_data_q <= push_data_s;
                    m_last_q <= rd_last_q;
                end else begin
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end
            end else if (rd_vld_q) begin
                if (!m_valid_q) begin
                    m_data_q  <= push_data_s;
                    m_last_q  <= rd_last_q;
                    m_valid_q <= 1'b1;
                end else begin
                    sk_data_q  <= push_data_s;
                    sk_last_q  <= rd_last_q;
                    sk_valid_q <= 1'b1;
                end
            end
        end
    end

    assign s_axi.awready = wr_rdy_q;
    assign s_axi.wready  = wr_rdy_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = rd_rdy_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    assign s_axis.tready = s_tready_q;

    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tstrb  = 4'hF;

endmodule

// File: tb/tb_accel_top.sv
// -----------------------------------------------------------------------------
// tb_accel_top.sv
// Self-checking bench for accel_top: register access, frame capture/replay with
// random data, modes and output back-pressure, saturation corners, buffer
// overflow and reset abort. Expected words come from an integer pixel model.
// -----------------------------------------------------------------------------
module tb_accel_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_if axil ();
    axis_if s_axis ();
    axis_if m_axis ();

    accel_top #(.FRAME_WORDS(576), .ADDR_W(10)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axi  (axil),
        .s_axis (s_axis),
        .m_axis (m_axis)
    );

    int          total_cnt = 0;
    int          bad_cnt   = 0;
    int          mdl_mode  = 0;
    int          mdl_param = 0;
    int          run_mode  = 0;
    int          run_param = 0;
    logic [31:0] in_words [0:599];
    logic [31:0] rd_val;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference edit: plain integer arithmetic per pixel.
    function automatic logic [31:0] ref_word(input logic [31:0] w, input int mode, input int p);
        logic [31:0] r;
        int x;
        int y;
        r = 32'h0;
        for (int b = 0; b < 4; b++) begin
            x = int'(w[b*8 +: 8]);
            case (mode)
                0:       y = 255 - x;
                1:       y = x;
                2:       y = (x + p > 255) ? 255 : x + p;
                3:       y = (x - p < 0) ? 0 : x - p;
                default: y = x;
            endcase
            r[b*8 +: 8] = 8'(y);
        end
        return r;
    endfunction

    task automatic axil_write(input logic [3:0] addr, input logic [31:0] data);
        int t;
        @(negedge clk);
        axil.awaddr  = {28'h0, addr};
        axil.wdata   = data;
        axil.wstrb   = 4'hF;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        axil.bready  = 1'b1;
        t = 0;
        while (!axil.awready && t < 20) begin @(negedge clk); t++; end
        check_val("aw_handshake", 32'(axil.awready & axil.wready), 32'd1);
        @(negedge clk);
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        t = 0;
        while (!axil.bvalid && t < 20) begin @(negedge clk); t++; end
        check_val("bvalid", 32'(axil.bvalid), 32'd1);
        check_val("bresp", 32'(axil.bresp), 32'd0);
        @(negedge clk);
        if (addr == 4'h4) mdl_mode = int'(data[1:0]);
        if (addr == 4'h8) mdl_param = int'(data[7:0]);
        if (addr == 4'h0 && data[0]) begin
            run_mode  = mdl_mode;
            run_param = mdl_param;
        end
    endtask

    task automatic axil_read(input logic [3:0] addr, output logic [31:0] data);
        int t;
        @(negedge clk);
        axil.araddr  = addr;
        axil.arvalid = 1'b1;
        axil.rready  = 1'b1;
        t = 0;
        while (!axil.arready && t < 20) begin @(negedge clk); t++; end
        check_val("ar_handshake", 32'(axil.arready), 32'd1);
        @(negedge clk);
        axil.arvalid = 1'b0;
        t = 0;
        while (!axil.rvalid && t < 20) begin @(negedge clk); t++; end
        check_val("rvalid", 32'(axil.rvalid), 32'd1);
        check_val("rresp", 32'(axil.rresp), 32'd0);
        data = axil.rdata;
        @(negedge clk);
    endtask

    // Streams in_words[0..n_beats-1] (tlast on beat tlast_at, -1 for none) and
    // collects exp_words outputs. rdy_mode: 0 always ready, 1 toggle, 2 random.
    task automatic run_frame(input string tag, input int n_beats, input int tlast_at,
                             input int exp_words, input int rdy_mode);
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        int          budget;
        int          last_cyc = 0;
        int          first_cyc = -1;
        int          extra = 0;
        int          s_rdy = 0;
        bit          pres = 1'b0;
        bit          acc = 1'b0;
        bit          stall_pend = 1'b0;
        bit          r;
        logic [31:0] stall_data = 32'h0;
        logic        stall_last = 1'b0;
        budget = exp_words * 6 + 200;
        while (got < exp_words && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pres && acc) begin
                sent++;
                last_cyc = cyc - 1;
            end
            if (sent < n_beats) begin
                s_axis.tdata  = in_words[sent];
                s_axis.tlast  = (sent == tlast_at);
                s_axis.tvalid = 1'b1;
                pres = 1'b1;
            end else begin
                s_axis.tvalid = 1'b0;
                s_axis.tlast  = 1'b0;
                pres = 1'b0;
            end
            acc = s_axis.tready;
            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = cyc[0];
                default: r = 1'($urandom_range(1, 0));
            endcase
            if (stall_pend) begin
                check_val({tag, "_hold_valid"}, 32'(m_axis.tvalid), 32'd1);
                check_val({tag, "_hold_data"}, m_axis.tdata, stall_data);
                check_val({tag, "_hold_last"}, 32'(m_axis.tlast), 32'(stall_last));
            end
            if (m_axis.tvalid && first_cyc < 0) first_cyc = cyc;
            if (m_axis.tvalid && r) begin
                check_val({tag, "_data"}, m_axis.tdata, ref_word(in_words[got], run_mode, run_param));
                check_val({tag, "_last"}, 32'(m_axis.tlast), 32'(got == exp_words - 1));
                got++;
            end
            stall_pend = m_axis.tvalid && !r;
            stall_data = m_axis.tdata;
            stall_last = m_axis.tlast;
            m_axis.tready = r;
        end
        check_val({tag, "_out_count"}, 32'(got), 32'(exp_words));
        check_val({tag, "_in_count"}, 32'(sent), 32'(exp_words));
        check_val({tag, "_latency_ok"}, 32'((first_cyc - last_cyc) <= 4), 32'd1);
        // Drain: nothing more may come out, and input stays closed.
        m_axis.tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_axis.tvalid) extra++;
            if (s_axis.tready) s_rdy++;
        end
        check_val({tag, "_extra_out"}, 32'(extra), 32'd0);
        check_val({tag, "_in_closed"}, 32'(s_rdy), 32'd0);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int sent;
        int cyc;
        bit acc;
        axil.awaddr = 32'h0; axil.awprot = 3'd0; axil.awvalid = 1'b0;
        axil.wdata = 32'h0; axil.wstrb = 4'h0; axil.wvalid = 1'b0; axil.bready = 1'b0;
        axil.araddr = 4'h0; axil.arprot = 3'd0; axil.arvalid = 1'b0; axil.rready = 1'b0;
        s_axis.tvalid = 1'b0; s_axis.tdata = 32'h0; s_axis.tstrb = 4'hF; s_axis.tlast = 1'b0;
        m_axis.tready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check_val("rst_m_tvalid", 32'(m_axis.tvalid), 32'd0);
        check_val("rst_m_tlast", 32'(m_axis.tlast), 32'd0);
        check_val("rst_m_tdata", m_axis.tdata, 32'd0);
        check_val("rst_m_tstrb", 32'(m_axis.tstrb), 32'hF);
        check_val("rst_s_tready", 32'(s_axis.tready), 32'd0);
        check_val("rst_bvalid", 32'(axil.bvalid), 32'd0);
        check_val("rst_rvalid", 32'(axil.rvalid), 32'd0);
        axil_read(4'hC, rd_val);
        check_val("rst_status", rd_val, 32'h0000_0000);
        axil_read(4'h4, rd_val);
        check_val("rst_mode", rd_val, 32'h0000_0000);

        // Full 576-word invert frame.
        for (int i = 0; i < 576; i++) begin
            in_words[i] = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
        end
        axil_write(4'h0, 32'h1);
        axil_read(4'hC, rd_val);
        check_val("busy_status", rd_val, 32'h0000_0001);
        axil_read(4'h0, rd_val);
        check_val("ctrl_reads0", rd_val, 32'h0000_0000);
        run_frame("full", 576, 575, 576, 0);
        axil_read(4'hC, rd_val);
        check_val("full_status", rd_val, 32'h0240_0002);

        // Saturation corners, single-word frames.
        axil_write(4'h4, 32'h2);
        axil_write(4'h8, 32'h10);
        axil_read(4'h8, rd_val);
        check_val("param_rb", rd_val, 32'h0000_0010);
        in_words[0] = 32'hF810_2000;
        axil_write(4'h0, 32'h1);
        run_frame("sat_hi", 1, 0, 1, 0);
        axil_write(4'h4, 32'h3);
        in_words[0] = 32'h0810_2000;
        axil_write(4'h0, 32'h1);
        run_frame("sat_lo", 1, 0, 1, 0);
        axil_read(4'hC, rd_val);
        check_val("one_status", rd_val, 32'h0001_0002);

        // Pass-through, 3 beats, toggling back-pressure.
        axil_write(4'h4, 32'h1);
        for (int i = 0; i < 4; i++) in_words[i] = $urandom;
        axil_write(4'h0, 32'h1);
        run_frame("toggle", 3, 2, 3, 1);
        axil_read(4'hC, rd_val);
        check_val("toggle_status", rd_val, 32'h0003_0002);

        // Random frames with random modes and random back-pressure.
        for (int k = 0; k < 3; k++) begin
            len = int'($urandom_range(40, 1));
            for (int i = 0; i < len; i++) in_words[i] = $urandom;
            axil_write(4'h4, 32'($urandom_range(3, 0)));
            axil_write(4'h8, 32'($urandom_range(255, 0)));
            axil_write(4'h0, 32'h1);
            run_frame("rnd", len, len - 1, len, 2);
            axil_read(4'hC, rd_val);
            check_val("rnd_status", rd_val, (32'(len) << 16) | 32'h2);
        end

        // Overflow: no tlast, a 577th beat is offered and must stall.
        axil_write(4'h4, 32'($urandom_range(3, 0)));
        for (int i = 0; i < 577; i++) in_words[i] = $urandom;
        axil_write(4'h0, 32'h1);
        run_frame("ovf", 577, -1, 576, 2);
        axil_read(4'hC, rd_val);
        check_val("ovf_status", rd_val, 32'h0240_0002);

        // Reset abort after 100 accepted beats, then a fresh 4-word frame.
        axil_write(4'h0, 32'h1);
        sent = 0;
        cyc = 0;
        acc = 1'b0;
        while (sent < 100 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (acc) sent++;
            if (sent < 100) begin
                s_axis.tdata  = $urandom;
                s_axis.tlast  = 1'b0;
                s_axis.tvalid = 1'b1;
            end else begin
                s_axis.tvalid = 1'b0;
            end
            acc = s_axis.tvalid && s_axis.tready;
        end
        check_val("abort_beats", 32'(sent), 32'd100);
        @(negedge clk);
        rst = 1'b1;
        s_axis.tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mdl_mode  = 0;
        mdl_param = 0;
        @(negedge clk);
        check_val("abort_tready", 32'(s_axis.tready), 32'd0);
        check_val("abort_tvalid", 32'(m_axis.tvalid), 32'd0);
        axil_read(4'hC, rd_val);
        check_val("abort_status", rd_val, 32'h0000_0000);
        axil_write(4'h4, 32'($urandom_range(3, 0)));
        axil_write(4'h8, 32'($urandom_range(255, 0)));
        for (int i = 0; i < 4; i++) in_words[i] = $urandom;
        axil_write(4'h0, 32'h1);
        run_frame("post_abort", 4, 3, 4, 2);
        axil_read(4'hC, rd_val);
        check_val("post_abort_status", rd_val, 32'h0004_0002);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
